pixel_buf_mem: RTL

Parametrised pixel staging memory between the AHB read-data path and the rotate engine's per-channel pixel fetch. Each cycle it accepts up to WR_LANES pixels unpacked from one bus beat, tracks which entries hold valid data, and serves RD_PORTS independent registered read channels (B/G/R and beyond). It replaces the fixed 4-lane/3-channel store with per-lane enables, validity tracking, miss flags, out-of-range protection and a frame-clear.

---
 rtl/pixel_buf_pkg.sv | 28 ++
 rtl/pixel_buf_rd_port.sv | 77 +++++++
 rtl/pixel_buf_mem.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pixel_buf_pkg.sv
// Shared constants and helpers for the pixel staging memory.
// Provides clog2, default parameter values and lane/port slice helpers.
package pixel_buf_pkg;

    localparam int PB_PIXEL_W  = 8;
    localparam int PB_DEPTH    = 64;
    localparam int PB_WR_LANES = 4;
    localparam int PB_RD_PORTS = 3;

    // Ceiling log2 with a floor of 1 so one-entry stores still get an address bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Low bit of slice idx in a vector of w-bit slices.
    function automatic int lane_lo(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic logic in_range(input int unsigned a,
                                      input int unsigned depth);
        return a < depth;
    endfunction

endpackage

// File: rtl/pixel_buf_rd_port.sv
// One registered read channel of pixel_buf_mem.
// Ports: clk/rst, raddr/ren request, arr_data/arr_valid from the store,
// wdata/waddr/wen write lanes (forwarding build only, PIXEL_BUF_BYPASS_EN),
// rdata/rvalid/rmiss registered result.
module pixel_buf_rd_port
    import pixel_buf_pkg::*;
#(
    parameter int PIXEL_W = PB_PIXEL_W,
    parameter int DEPTH   = PB_DEPTH,
    parameter int ADDR_W  = clog2(PB_DEPTH),
`ifdef PIXEL_BUF_BYPASS_EN
    parameter int WR_LANES = PB_WR_LANES,
`endif
    parameter logic [PIXEL_W-1:0] FILL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            raddr,
    input  logic                         ren,
    input  logic [PIXEL_W-1:0]           arr_data,
    input  logic                         arr_valid,
`ifdef PIXEL_BUF_BYPASS_EN
    input  logic [WR_LANES*PIXEL_W-1:0]  wdata,
    input  logic [WR_LANES*ADDR_W-1:0]   waddr,
    input  logic [WR_LANES-1:0]          wen,
`endif
    output logic [PIXEL_W-1:0]           rdata,
    output logic                         rvalid,
    output logic                         rmiss
);

    logic               in_rng;
    logic               miss;
    logic [PIXEL_W-1:0] data_sel;

    assign in_rng = in_range(32'(raddr), DEPTH);

`ifdef PIXEL_BUF_BYPASS_EN
    logic               hit;
    logic [PIXEL_W-1:0] fwd;

    // Ascending scan: the highest matching lane is assigned last and wins.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int k = 0; k < WR_LANES; k++) begin
            if (wen[k]
                && in_range(32'(waddr[lane_lo(k, ADDR_W) +: ADDR_W]), DEPTH)
                && (waddr[lane_lo(k, ADDR_W) +: ADDR_W] == raddr)) begin
                hit = 1'b1;
                fwd = wdata[lane_lo(k, PIXEL_W) +: PIXEL_W];
            end
        end
    end

    assign miss     = !hit && !(in_rng && arr_valid);
    assign data_sel = hit ? fwd : arr_data;
`else
    assign miss     = !(in_rng && arr_valid);
    assign data_sel = arr_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            rmiss  <= 1'b0;
        end else begin
            rvalid <= ren;
            rmiss  <= ren && miss;
            if (ren) begin
                rdata <= miss ? FILL : data_sel;
            end
        end
    end

endmodule

// File: rtl/pixel_buf_mem.sv
// Pixel staging memory between the AHB read-data path and the rotate engine.
// Ports: I_HCLK, I_HRESET (async, active high), I_CLR frame clear,
// I_WDATA/I_WADDR/I_WEN write lanes, I_RADDR/I_REN read requests,
// O_RDATA/O_RVALID/O_RMISS per-port results, O_FILL_CNT/O_ALL_VALID occupancy.
// Define PIXEL_BUF_BYPASS_EN for write-first forwarding; default is read-first.
module pixel_buf_mem
    import pixel_buf_pkg::*;
#(
    parameter int PIXEL_W  = PB_PIXEL_W,
    parameter int DEPTH    = PB_DEPTH,
    parameter int WR_LANES = PB_WR_LANES,
    parameter int RD_PORTS = PB_RD_PORTS,
    parameter logic [PIXEL_W-1:0] FILL = '0,
    localparam int ADDR_W  = clog2(DEPTH),
    localparam int CNT_W   = clog2(DEPTH + 1)
) (
    input  logic                         I_HCLK,
    input  logic                         I_HRESET,
    input  logic                         I_CLR,
    input  logic [WR_LANES*PIXEL_W-1:0]  I_WDATA,
    input  logic [WR_LANES*ADDR_W-1:0]   I_WADDR,
    input  logic [WR_LANES-1:0]          I_WEN,
    input  logic [RD_PORTS*ADDR_W-1:0]   I_RADDR,
    input  logic [RD_PORTS-1:0]          I_REN,
    output logic [RD_PORTS*PIXEL_W-1:0]  O_RDATA,
    output logic [RD_PORTS-1:0]          O_RVALID,
    output logic [RD_PORTS-1:0]          O_RMISS,
    output logic [CNT_W-1:0]             O_FILL_CNT,
    output logic                         O_ALL_VALID
);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [CNT_W-1:0]   cnt_d;

    logic [ADDR_W-1:0]  lane_addr [WR_LANES];
    logic [WR_LANES-1:0] lane_ok;

    always_comb begin
        for (int k = 0; k < WR_LANES; k++) begin
            lane_addr[k] = I_WADDR[lane_lo(k, ADDR_W) +: ADDR_W];
            lane_ok[k]   = I_WEN[k] && in_range(32'(lane_addr[k]), DEPTH);
        end
    end

    // Later lanes overwrite earlier ones, so the highest lane wins a collision.
    always_ff @(posedge I_HCLK) begin
        for (int k = 0; k < WR_LANES; k++) begin
            if (lane_ok[k]) begin
                mem[lane_addr[k]] <= I_WDATA[lane_lo(k, PIXEL_W) +: PIXEL_W];
            end
        end
    end

    // Clear first, then same-cycle writes re-validate their entries.
    always_comb begin
        valid_d = I_CLR ? '0 : valid_q;
        for (int k = 0; k < WR_LANES; k++) begin
            if (lane_ok[k]) begin
                valid_d[lane_addr[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            valid_q     <= '0;
            O_FILL_CNT  <= '0;
            O_ALL_VALID <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            O_FILL_CNT  <= cnt_d;
            O_ALL_VALID <= (cnt_d == CNT_W'(DEPTH));
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0]  raddr;
        logic [PIXEL_W-1:0] arr_data;
        logic               arr_valid;

        assign raddr     = I_RADDR[lane_lo(p, ADDR_W) +: ADDR_W];
        assign arr_data  = mem[raddr];
        // A same-cycle clear hides the old contents; only forwarding can hit.
        assign arr_valid = valid_q[raddr] && !I_CLR;

        pixel_buf_rd_port #(
            .PIXEL_W  (PIXEL_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
`ifdef PIXEL_BUF_BYPASS_EN
            .WR_LANES (WR_LANES),
`endif
            .FILL     (FILL)
        ) u_port (
            .clk       (I_HCLK),
            .rst       (I_HRESET),
            .raddr     (raddr),
            .ren       (I_REN[p]),
            .arr_data  (arr_data),
            .arr_valid (arr_valid),
`ifdef PIXEL_BUF_BYPASS_EN
            .wdata     (I_WDATA),
            .waddr     (I_WADDR),
            .wen       (I_WEN),
`endif
            .rdata     (O_RDATA[lane_lo(p, PIXEL_W) +: PIXEL_W]),
            .rvalid    (O_RVALID[p]),
            .rmiss     (O_RMISS[p])
        );
    end

endmodule
